// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard and sequencing controller for the rv32 5-stage pipeline.
//               It generates the hold and NOP-insert controls for the pipeline
//               registers and the PC from three sources, listed here from
//               highest to lowest priority:
//               data-memory wait / timeout, MA-resolved redirect, load-use
//               interlock.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAX_WAIT         maximum consecutive MA wait cycles before TIMEOUT (2..255)
//   CNT_W            width of the saturating stall counter
// Ports
//   clk              clock, controller state updates on rising edge
//   resetn           synchronous active-low reset
//   i_id_inst        instruction in ID (0 = bubble)
//   i_ex_inst        instruction in EX
//   i_ma_inst        instruction in MA
//   i_redirect_ma    MA resolved a taken branch / JAL / JALR
//   i_dmem_ready     data memory completes the MA access this cycle
//   o_hold_pc        PC keeps its value
//   o_hold_if_id     IF_ID keeps its contents
//   o_hold_id_ex     ID_EX keeps its contents
//   o_hold_ex_ma     EX_MA keeps its contents
//   o_nop_if_id      IF_ID loads a bubble
//   o_nop_id_ex      ID_EX loads a bubble
//   o_nop_ex_ma      EX_MA loads a bubble
//   o_nop_ma_wb      MA_WB loads a bubble
//   o_redirect_pc    PC mux selects the MA target
//   o_mem_timeout    sticky data-memory timeout flag
//   o_stall_cnt      saturating count of cycles with o_hold_pc = 1
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [31:0]      i_id_inst,
   input  logic [31:0]      i_ex_inst,
   input  logic [31:0]      i_ma_inst,
   input  logic             i_redirect_ma,
   input  logic             i_dmem_ready,
   output logic             o_hold_pc,
   output logic             o_hold_if_id,
   output logic             o_hold_id_ex,
   output logic             o_hold_ex_ma,
   output logic             o_nop_if_id,
   output logic             o_nop_id_ex,
   output logic             o_nop_ex_ma,
   output logic             o_nop_ma_wb,
   output logic             o_redirect_pc,
   output logic             o_mem_timeout,
   output logic [CNT_W-1:0] o_stall_cnt
);

   // Opcodes
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_REG    = 7'b0110011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

   // FSM encoding
   localparam logic [1:0] c_ST_RUN      = 2'd0;
   localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] c_ST_TIMEOUT  = 2'd2;

   localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

   logic [1:0]       r_state;
   logic [7:0]       r_wait_cnt;
   logic             r_mem_timeout;
   logic [CNT_W-1:0] r_stall_cnt;

   logic [1:0]       w_state_nxt;
   logic [7:0]       w_wait_nxt;
   logic             w_timeout_set;

   // ------------------------------------------------------------------------
   // Instruction decode
   // ------------------------------------------------------------------------
   logic [6:0] w_id_op;
   logic [6:0] w_ex_op;
   logic [6:0] w_ma_op;
   logic [4:0] w_rs1_id;
   logic [4:0] w_rs2_id;
   logic [4:0] w_rd_ex;
   logic       w_rs1_used;
   logic       w_rs2_used;
   logic       w_ex_load;
   logic       w_ma_mem;
   logic       w_mem_stall;
   logic       w_load_use;

   assign w_id_op  = i_id_inst[6:0];
   assign w_ex_op  = i_ex_inst[6:0];
   assign w_ma_op  = i_ma_inst[6:0];
   assign w_rs1_id = i_id_inst[19:15];
   assign w_rs2_id = i_id_inst[24:20];
   assign w_rd_ex  = i_ex_inst[11:7];

   assign w_rs1_used = !((w_id_op == c_OP_LUI) || (w_id_op == c_OP_AUIPC) ||
                         (w_id_op == c_OP_JAL));
   assign w_rs2_used = (w_id_op == c_OP_REG) || (w_id_op == c_OP_STORE) ||
                       (w_id_op == c_OP_BRANCH);

   assign w_ex_load = (w_ex_op == c_OP_LOAD);
   assign w_ma_mem  = (w_ma_op == c_OP_LOAD) || (w_ma_op == c_OP_STORE);

   // Once in TIMEOUT the memory is no longer waited on; TIMEOUT drives its
   // own hold pattern.
   assign w_mem_stall = w_ma_mem && !i_dmem_ready && (r_state != c_ST_TIMEOUT);

   // x0 as destination never creates a dependency.
   assign w_load_use = w_ex_load && (w_rd_ex != 5'd0) &&
                       ((w_rs1_used && (w_rs1_id == w_rd_ex)) ||
                        (w_rs2_used && (w_rs2_id == w_rd_ex)));

   // Instruction fields this controller does not decode.
   logic w_unused_bits;
   assign w_unused_bits = &{1'b0, i_id_inst[31:25], i_id_inst[14:7],
                            i_ex_inst[31:12], i_ma_inst[31:7]};

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state       <= c_ST_RUN;
         r_wait_cnt    <= 8'd0;
         r_mem_timeout <= 1'b0;
         r_stall_cnt   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_timeout_set) begin
            r_mem_timeout <= 1'b1;
         end
         if (o_hold_pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait_cnt;
      w_timeout_set = 1'b0;
      case (r_state)
         c_ST_RUN: begin
            if (w_mem_stall) begin
               w_state_nxt = c_ST_MEM_WAIT;
               w_wait_nxt  = 8'd1;
            end
         end
         c_ST_MEM_WAIT: begin
            // r_wait_cnt counts stall cycles already completed, so the
            // MAX_WAIT-th consecutive stall cycle lands on c_WAIT_LAST.
            if (!w_mem_stall) begin
               w_state_nxt = c_ST_RUN;
               w_wait_nxt  = 8'd0;
            end else if (r_wait_cnt == c_WAIT_LAST) begin
               w_state_nxt   = c_ST_TIMEOUT;
               w_timeout_set = 1'b1;
            end else begin
               w_wait_nxt = r_wait_cnt + 8'd1;
            end
         end
         c_ST_TIMEOUT: begin
            w_state_nxt = c_ST_TIMEOUT;
         end
         default: begin
            w_state_nxt = c_ST_RUN;
            w_wait_nxt  = 8'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------------
   logic w_hold_pc;
   logic w_hold_if_id;
   logic w_hold_id_ex;
   logic w_hold_ex_ma;
   logic w_nop_if_id;
   logic w_nop_id_ex;
   logic w_nop_ex_ma;
   logic w_nop_ma_wb;
   logic w_redirect_pc;

   always_comb begin
      w_hold_pc     = 1'b0;
      w_hold_if_id  = 1'b0;
      w_hold_id_ex  = 1'b0;
      w_hold_ex_ma  = 1'b0;
      w_nop_if_id   = 1'b0;
      w_nop_id_ex   = 1'b0;
      w_nop_ex_ma   = 1'b0;
      w_nop_ma_wb   = 1'b0;
      w_redirect_pc = 1'b0;
      if (resetn) begin
         if ((r_state == c_ST_TIMEOUT) || w_mem_stall) begin
            // Freeze everything up to MA; a pending redirect re-presents
            // once MA completes.
            w_hold_pc    = 1'b1;
            w_hold_if_id = 1'b1;
            w_hold_id_ex = 1'b1;
            w_hold_ex_ma = 1'b1;
            w_nop_ma_wb  = 1'b1;
         end else if (i_redirect_ma) begin
            w_redirect_pc = 1'b1;
            w_nop_if_id   = 1'b1;
            w_nop_id_ex   = 1'b1;
            w_nop_ex_ma   = 1'b1;
         end else if (w_load_use) begin
            w_hold_pc    = 1'b1;
            w_hold_if_id = 1'b1;
            w_nop_id_ex  = 1'b1;
         end
      end
   end

   // A bubble request always wins over a hold on the same register.
   assign o_hold_pc     = w_hold_pc;
   assign o_hold_if_id  = w_hold_if_id & ~w_nop_if_id;
   assign o_hold_id_ex  = w_hold_id_ex & ~w_nop_id_ex;
   assign o_hold_ex_ma  = w_hold_ex_ma & ~w_nop_ex_ma;
   assign o_nop_if_id   = w_nop_if_id;
   assign o_nop_id_ex   = w_nop_id_ex;
   assign o_nop_ex_ma   = w_nop_ex_ma;
   assign o_nop_ma_wb   = w_nop_ma_wb;
   assign o_redirect_pc = w_redirect_pc;
   assign o_mem_timeout = r_mem_timeout;
   assign o_stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed, table-driven self-checking bench for
//               pipe_hazard_ctrl (MAX_WAIT = 4, CNT_W = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 4;

   // Instruction encodings
   localparam logic [31:0] c_NOP  = 32'h0000_0000;
   localparam logic [31:0] c_LW   = 32'h0000_A103; // lw   x2,0(x1)
   localparam logic [31:0] c_LW0  = 32'h0000_A003; // lw   x0,0(x1)
   localparam logic [31:0] c_ADD  = 32'h0021_0233; // add  x4,x2,x2
   localparam logic [31:0] c_SW   = 32'h0020_A023; // sw   x2,0(x1)
   localparam logic [31:0] c_ADDI = 32'h0022_8213; // addi x4,x5,2 (rs2 field = 2, unused)
   localparam logic [31:0] c_LUI  = 32'h0001_02B7; // lui  x5 (rs1 field = 2, unused)
   localparam logic [31:0] c_BEQ  = 32'h0020_8463; // beq  x1,x2

   // Output vector bit order:
   // {hold_pc, hold_if_id, hold_id_ex, hold_ex_ma,
   //  nop_if_id, nop_id_ex, nop_ex_ma, nop_ma_wb, redirect_pc}
   localparam logic [8:0] c_P0 = 9'b0000_0000_0;
   localparam logic [8:0] c_LU = 9'b1100_0100_0;
   localparam logic [8:0] c_RD = 9'b0000_1110_1;
   localparam logic [8:0] c_MS = 9'b1111_0001_0;

   typedef struct {
      logic             rstn;
      logic [31:0]      id;
      logic [31:0]      ex;
      logic [31:0]      ma;
      logic             redir;
      logic             rdy;
      logic [8:0]       exp_out;
      logic             exp_to;
      logic [CNT_W-1:0] exp_cnt;
   } vec_t;

   logic             clk;
   logic             resetn;
   logic [31:0]      id_inst;
   logic [31:0]      ex_inst;
   logic [31:0]      ma_inst;
   logic             redirect_ma;
   logic             dmem_ready;
   logic             hold_pc;
   logic             hold_if_id;
   logic             hold_id_ex;
   logic             hold_ex_ma;
   logic             nop_if_id;
   logic             nop_id_ex;
   logic             nop_ex_ma;
   logic             nop_ma_wb;
   logic             redirect_pc;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;

   int   n_checks;
   int   n_errors;
   vec_t vecs[$];

   pipe_hazard_ctrl #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .i_id_inst     (id_inst),
      .i_ex_inst     (ex_inst),
      .i_ma_inst     (ma_inst),
      .i_redirect_ma (redirect_ma),
      .i_dmem_ready  (dmem_ready),
      .o_hold_pc     (hold_pc),
      .o_hold_if_id  (hold_if_id),
      .o_hold_id_ex  (hold_id_ex),
      .o_hold_ex_ma  (hold_ex_ma),
      .o_nop_if_id   (nop_if_id),
      .o_nop_id_ex   (nop_id_ex),
      .o_nop_ex_ma   (nop_ex_ma),
      .o_nop_ma_wb   (nop_ma_wb),
      .o_redirect_pc (redirect_pc),
      .o_mem_timeout (mem_timeout),
      .o_stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [31:0] id, input logic [31:0] ex,
                      input logic [31:0] ma, input logic rd, input logic rdy,
                      input logic [8:0] eo, input logic eto, input int ecnt);
      vec_t v;
      v.rstn    = r;
      v.id      = id;
      v.ex      = ex;
      v.ma      = ma;
      v.redir   = rd;
      v.rdy     = rdy;
      v.exp_out = eo;
      v.exp_to  = eto;
      v.exp_cnt = CNT_W'(ecnt);
      vecs.push_back(v);
   endtask

   // Drive one cycle: outputs are compared mid-cycle, registered state
   // just after the following rising edge.
   task automatic run_vec(input vec_t v, input int idx);
      logic [8:0] got;
      resetn      = v.rstn;
      id_inst     = v.id;
      ex_inst     = v.ex;
      ma_inst     = v.ma;
      redirect_ma = v.redir;
      dmem_ready  = v.rdy;
      #2;
      got = {hold_pc, hold_if_id, hold_id_ex, hold_ex_ma,
             nop_if_id, nop_id_ex, nop_ex_ma, nop_ma_wb, redirect_pc};
      n_checks++;
      if (got !== v.exp_out) begin
         n_errors++;
         $display("FAIL outputs vec %0d: got %b expected %b", idx, got, v.exp_out);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (mem_timeout !== v.exp_to) begin
         n_errors++;
         $display("FAIL mem_timeout vec %0d: got %b expected %b", idx, mem_timeout, v.exp_to);
      end
      n_checks++;
      if (stall_cnt !== v.exp_cnt) begin
         n_errors++;
         $display("FAIL stall_cnt vec %0d: got %0d expected %0d", idx, stall_cnt, v.exp_cnt);
      end
   endtask

   initial begin
      int exp_cnt;
      vec_t v;
      n_checks    = 0;
      n_errors    = 0;
      resetn      = 1'b0;
      id_inst     = c_NOP;
      ex_inst     = c_NOP;
      ma_inst     = c_NOP;
      redirect_ma = 1'b0;
      dmem_ready  = 1'b0;

      //   rstn id      ex     ma     redir rdy out   to cnt
      // reset forces outputs low despite hazards on the inputs
      add(0, c_ADD,  c_LW,  c_LW,  1, 0, c_P0, 0, 0);
      add(1, c_NOP,  c_NOP, c_NOP, 0, 0, c_P0, 0, 0);
      // load-use interlock and its non-matching variants
      add(1, c_ADD,  c_LW,  c_NOP, 0, 0, c_LU, 0, 1);
      add(1, c_ADD,  c_NOP, c_NOP, 0, 0, c_P0, 0, 1);
      add(1, c_ADD,  c_LW0, c_NOP, 0, 0, c_P0, 0, 1);
      add(1, c_SW,   c_LW,  c_NOP, 0, 0, c_LU, 0, 2);
      add(1, c_ADDI, c_LW,  c_NOP, 0, 0, c_P0, 0, 2);
      add(1, c_LUI,  c_LW,  c_NOP, 0, 0, c_P0, 0, 2);
      add(1, c_NOP,  c_LW,  c_NOP, 0, 0, c_P0, 0, 2);
      // redirect, alone and over a load-use
      add(1, c_NOP,  c_NOP, c_BEQ, 1, 1, c_RD, 0, 2);
      add(1, c_ADD,  c_LW,  c_BEQ, 1, 1, c_RD, 0, 2);
      // zero-wait store
      add(1, c_NOP,  c_NOP, c_SW,  0, 1, c_P0, 0, 2);
      // 3-cycle memory wait with redirect + load-use masked during the wait
      add(1, c_NOP,  c_NOP, c_LW,  0, 0, c_MS, 0, 3);
      add(1, c_ADD,  c_LW,  c_LW,  1, 0, c_MS, 0, 4);
      add(1, c_NOP,  c_NOP, c_LW,  0, 0, c_MS, 0, 5);
      add(1, c_NOP,  c_NOP, c_LW,  1, 1, c_RD, 0, 5);
      add(1, c_NOP,  c_NOP, c_NOP, 0, 0, c_P0, 0, 5);
      // timeout after MAX_WAIT = 4 wait cycles, then sticky
      add(1, c_NOP,  c_NOP, c_LW,  0, 0, c_MS, 0, 6);
      add(1, c_NOP,  c_NOP, c_LW,  0, 0, c_MS, 0, 7);
      add(1, c_NOP,  c_NOP, c_LW,  0, 0, c_MS, 0, 8);
      add(1, c_NOP,  c_NOP, c_LW,  0, 0, c_MS, 1, 9);
      add(1, c_NOP,  c_NOP, c_LW,  1, 1, c_MS, 1, 10);
      add(1, c_ADD,  c_LW,  c_NOP, 0, 0, c_MS, 1, 11);
      // reset out of TIMEOUT, then normal load-use
      add(0, c_ADD,  c_LW,  c_LW,  1, 0, c_P0, 0, 0);
      add(1, c_ADD,  c_LW,  c_NOP, 0, 0, c_LU, 0, 1);
      // reset in MEM_WAIT with wait_cnt = 2
      add(1, c_NOP,  c_NOP, c_LW,  0, 0, c_MS, 0, 2);
      add(1, c_NOP,  c_NOP, c_LW,  0, 0, c_MS, 0, 3);
      add(0, c_NOP,  c_NOP, c_LW,  0, 0, c_P0, 0, 0);
      add(1, c_ADD,  c_LW,  c_NOP, 0, 0, c_LU, 0, 1);
      // fresh 3-cycle wait after reset must not time out
      add(1, c_NOP,  c_NOP, c_LW,  0, 0, c_MS, 0, 2);
      add(1, c_NOP,  c_NOP, c_LW,  0, 0, c_MS, 0, 3);
      add(1, c_NOP,  c_NOP, c_LW,  0, 0, c_MS, 0, 4);
      add(1, c_NOP,  c_NOP, c_LW,  0, 1, c_P0, 0, 4);

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i], i);
      end

      // Stall counter saturation: hold the load-use for 14 cycles from 4.
      exp_cnt = 4;
      for (int k = 0; k < 14; k++) begin
         exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
         v.rstn    = 1'b1;
         v.id      = c_ADD;
         v.ex      = c_LW;
         v.ma      = c_NOP;
         v.redir   = 1'b0;
         v.rdy     = 1'b0;
         v.exp_out = c_LU;
         v.exp_to  = 1'b0;
         v.exp_cnt = CNT_W'(exp_cnt);
         run_vec(v, 1000 + k);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the rv32 5-stage pipeline (IF, ID, EX, MA, WB). It watches the instructions resident in ID, EX and MA and generates per-register hold and NOP-insert controls for IF_ID, ID_EX, EX_MA and MA_WB, plus the PC hold. It covers three cases: load-use interlocks, control-flow redirects resolved in MA, and multi-cycle data-memory waits with a timeout. All outputs settle within the high phase, before the negedge capture of the pipeline registers.

Parameters:
MAX_WAIT, 16, max consecutive cycles a MA load/store may wait on dmem_ready before TIMEOUT (range 2..255)
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  clock; controller state updates on rising edge
resetn  in  1  reset, synchronous, active-low
id_inst  in  32  instruction in ID (0 = bubble)
ex_inst  in  32  instruction in EX
ma_inst  in  32  instruction in MA
redirect_ma  in  1  MA resolved a taken branch / JAL / JALR this cycle
dmem_ready  in  1  data memory completes the MA access this cycle
hold_pc  out  1  PC keeps its value
hold_if_id  out  1  IF_ID keeps its contents
hold_id_ex  out  1  ID_EX keeps its contents
hold_ex_ma  out  1  EX_MA keeps its contents
nop_if_id  out  1  IF_ID loads a bubble
nop_id_ex  out  1  ID_EX loads a bubble
nop_ex_ma  out  1  EX_MA loads a bubble
nop_ma_wb  out  1  MA_WB loads a bubble
redirect_pc  out  1  PC mux selects the MA target
mem_timeout  out  1  sticky error flag
stall_cnt  out  CNT_W  cycles with hold_pc=1, saturating

Behaviour:
- Decode uses opcode bits [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- Load: opcode 0000011. Store: 0100011. mem_op = load or store.
- rs1 is used unless the opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111). rs2 is used only for 0110011, 0100011 and 1100011.
- mem_stall = mem_op(ma_inst) && !dmem_ready && state != TIMEOUT.
- load_use = load(ex_inst) && rd_ex != 0 && ((rs1 used && rs1_id == rd_ex) || (rs2 used && rs2_id == rd_ex)).
- Outputs are combinational from state and inputs. Priority, highest first:
  1. TIMEOUT state: hold_pc, hold_if_id, hold_id_ex, hold_ex_ma = 1; nop_ma_wb = 1; redirect_pc = 0.
  2. mem_stall: same hold pattern and nop_ma_wb = 1. Any redirect_ma is ignored this cycle; it re-presents when MA completes.
  3. redirect_ma: redirect_pc = 1; nop_if_id, nop_id_ex, nop_ex_ma = 1; no holds.
  4. load_use: hold_pc = 1, hold_if_id = 1, nop_id_ex = 1. Exactly one bubble per occurrence.
  5. Otherwise all outputs 0.
- A NOP request dominates a hold on the same register. Only one of hold/nop is ever asserted per register.
- FSM states: RUN, MEM_WAIT, TIMEOUT. Register wait_cnt is 8 bits.
  - RUN: if mem_stall, go to MEM_WAIT with wait_cnt = 1; else stay.
  - MEM_WAIT on dmem_ready: go to RUN, wait_cnt = 0.
  - MEM_WAIT, not ready, wait_cnt == MAX_WAIT-1: go to TIMEOUT and set mem_timeout.
  - MEM_WAIT, otherwise: wait_cnt += 1.
  - TIMEOUT: absorbing until reset.
- Latency: a wait of N cycles (ready in cycle N+1) gives exactly N hold cycles. Zero-wait accesses produce no stall.
- stall_cnt increments on each rising edge where hold_pc = 1 and saturates at all-ones.
- Reset (resetn = 0 at a rising edge), from any state including mid-MEM_WAIT or TIMEOUT:
  - state = RUN, wait_cnt = 0, mem_timeout = 0, stall_cnt = 0.
  - While resetn = 0, every combinational output is forced to 0.
- Bubble instructions (0x00000000) never match load/store/branch decode. The rd = x0 destination never triggers load_use.

Test Plan:
1. Load-use interlock: ex_inst = 0x0000A103 (lw x2,0(x1)), id_inst = 0x00210233 (add x4,x2,x2), dmem idle -> one cycle with hold_pc = hold_if_id = nop_id_ex = 1; stall_cnt 0 -> 1. Repeat with rd = x0 -> no stall.
2. Redirect: redirect_ma = 1, ma_inst = 0x00208463 (beq), dmem_ready = 1 -> redirect_pc = nop_if_id = nop_id_ex = nop_ex_ma = 1 for one cycle; no holds.
3. Memory wait of 3 cycles: ma_inst = lw, dmem_ready low 3 cycles then high -> holds and nop_ma_wb asserted exactly 3 cycles; state RUN -> MEM_WAIT -> RUN; stall_cnt += 3.
4. Simultaneous events: redirect_ma = 1 and load_use during a mem_stall -> only the mem_stall pattern is driven. On the cycle dmem_ready = 1, the redirect pattern is driven.
5. Timeout: MAX_WAIT = 4, dmem_ready held low -> TIMEOUT entered after the 4th wait cycle; mem_timeout = 1 and stays 1 when dmem_ready later rises.
6. Reset mid-operation: assert resetn = 0 for one edge while in MEM_WAIT (wait_cnt = 2) and again from TIMEOUT -> all outputs 0, stall_cnt = 0, mem_timeout = 0; next load-use behaves as in scenario 1.
